daa_booth_mac: RTL

- Parametrised successor to the fixed 4-bit Booth/DAA neural-engine MAC.
- Accepts a stream of (activation, radix-4 Booth weight digit) pairs over a valid/ready handshake and accumulates the partial products into an ACC_W-bit signed accumulator. On overflow, dynamic accumulator alignment right-shifts the accumulator and increments a shared exponent.
- New over the previous block:
  - configurable widths;
  - framed dot products (last flag) with an output handshake;
  - saturation with a sticky flag when the exponent is exhausted;
  - a product counter.

---
 rtl/daa_booth_mac_if.sv | 32 +++
 rtl/daa_booth_mac.sv | 115 +++++++++++
 2 files changed

// File: rtl/daa_booth_mac_if.sv
// Pair-stream / result handshake bundle for the Booth/DAA MAC.
// The master side is the producer/consumer; the slave side is the MAC itself.
interface daa_booth_mac_if #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 10,
    parameter int EXP_W = 3,
    parameter int CNT_W = 6
);
    logic             clear;
    logic             signed_en;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  act;
    logic [2:0]       w;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [EXP_W-1:0] out_exp;
    logic [CNT_W-1:0] out_cnt;
    logic             out_sat;

    modport master (
        output clear, signed_en, in_valid, act, w, last, out_ready,
        input  in_ready, out_valid, out_acc, out_exp, out_cnt, out_sat
    );

    modport slave (
        input  clear, signed_en, in_valid, act, w, last, out_ready,
        output in_ready, out_valid, out_acc, out_exp, out_cnt, out_sat
    );
endinterface

// File: rtl/daa_booth_mac.sv
// Framed radix-4 Booth MAC with dynamic accumulator alignment: on overflow the
// mantissa is halved and a shared exponent bumped; saturates once exponent is spent.
module daa_booth_mac #(
    parameter int IN_W  = 4,
    parameter int ACC_W = 10,
    parameter int EXP_W = 3,
    parameter int CNT_W = 6
) (
    input logic            clk,
    input logic            rst,
    daa_booth_mac_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [EXP_W-1:0] MAX_SHIFT = '1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [IN_W:0]          a_ext;
    logic signed [IN_W+1:0] a2, p, p_sh;
    logic [ACC_W:0]         pa, s;
    logic                   ovf, in_rdy, accept;

    // Product path: |d*act| always fits IN_W+2 bits since the unsigned case
    // never reaches -2^IN_W, so negation cannot wrap.
    always_comb begin
        a_ext = bus.signed_en ? {bus.act[IN_W-1], bus.act} : {1'b0, bus.act};
        a2    = {a_ext[IN_W], a_ext};
        case (bus.w)
            3'b001, 3'b010: p = a2;
            3'b011:         p = {a_ext, 1'b0};
            3'b100:         p = '0 - {a_ext, 1'b0};
            3'b101, 3'b110: p = '0 - a2;
            default:        p = '0;
        endcase
        p_sh = p >>> exp_q;
        pa   = {{(ACC_W-IN_W-1){p_sh[IN_W+1]}}, p_sh};
        s    = {acc_q[ACC_W-1], acc_q} + pa;
        ovf  = s[ACC_W] ^ s[ACC_W-1];
    end

    assign in_rdy        = (state_q != DONE);
    assign accept        = bus.in_valid & in_rdy;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_acc   = acc_q;
    assign bus.out_exp   = exp_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_sat   = sat_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if (!ovf) begin
                        acc_d = s[ACC_W-1:0];
                    end else if (exp_q != MAX_SHIFT) begin
                        acc_d = s[ACC_W:1];
                        exp_d = exp_q + EXP_W'(1);
                    end else begin
                        acc_d = s[ACC_W] ? ACC_MIN : ACC_MAX;
                        sat_d = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    state_d = bus.last ? DONE : ACC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    exp_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            exp_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end
endmodule
